bit_unstuffer: RTL and testbench

//  Receive-side counterpart of the transmit bit stuffer. Accepts the NRZI-decoded serial

---
 rtl/bit_unstuffer_pkg.sv | 15 +
 rtl/bit_unstuffer_if.sv | 27 ++
 rtl/bit_unstuffer_ones_run_counter.sv | 40 ++++
 rtl/bit_unstuffer.sv | 117 +++++++++++
 tb/tb_bit_unstuffer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bit_unstuffer_pkg.sv
// Shared types and constants for the serial bit-stuffing datapath.
package bit_unstuffer_pkg;

    localparam int unsigned STUFF_RUN_LEN = 6;
    localparam int unsigned RUN_W         = 3;
    localparam int unsigned REMOVED_W     = 4;

    typedef enum logic [1:0] {
        UNS_IDLE,
        UNS_DATA,
        UNS_DROP,
        UNS_ERR
    } unstuff_state_t;

endpackage

// File: rtl/bit_unstuffer_if.sv
// Packet framing, serial input and unstuffed output bundle of the unstuffer.
interface bit_unstuffer_if #(
    parameter int unsigned CNT_W = 7
);
    import bit_unstuffer_pkg::*;

    logic                 pkt_start;
    logic                 pkt_end;
    logic                 bstr_in;
    logic                 bstr_in_ready;
    logic                 bstr_out;
    logic                 bstr_out_ready;
    logic                 stuff_err;
    logic [REMOVED_W-1:0] bits_removed;
    logic [CNT_W-1:0]     bit_count;

    modport master (
        output pkt_start, pkt_end, bstr_in, bstr_in_ready,
        input  bstr_out, bstr_out_ready, stuff_err, bits_removed, bit_count
    );

    modport slave (
        input  pkt_start, pkt_end, bstr_in, bstr_in_ready,
        output bstr_out, bstr_out_ready, stuff_err, bits_removed, bit_count
    );

endinterface

// File: rtl/bit_unstuffer_ones_run_counter.sv
// Counts consecutive 1s; flags the 1 that completes a full stuffing run.
module ones_run_counter
    import bit_unstuffer_pkg::*;
#(
    parameter int unsigned RUN_LEN = STUFF_RUN_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_c
);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [RUN_W-1:0] base_c;

    // Clear applies before increment so a clear+inc leaves a run of one.
    always_comb begin
        base_c = clr_i ? '0 : run_q;
        run_d  = base_c;
        hit_c  = 1'b0;
        if (inc_i) begin
            if (base_c != RUN_W'(RUN_LEN)) begin
                run_d = base_c + RUN_W'(1);
            end
            hit_c = (base_c == RUN_W'(RUN_LEN - 1));
        end
    end

    // Run register.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/bit_unstuffer.sv
// Receive-side bit unstuffer: drops the 0 after each run of STUFF_RUN 1s, flags violations.
module bit_unstuffer
    import bit_unstuffer_pkg::*;
#(
    parameter int unsigned STUFF_RUN = STUFF_RUN_LEN,
    parameter int unsigned CNT_W     = 7
) (
    input  logic            clk,
    input  logic            rst,
    bit_unstuffer_if.slave  bus_if
);

    unstuff_state_t       state_q, state_d, eff_state_c;
    logic                 out_q, out_d;
    logic                 out_ready_q, out_ready_d;
    logic                 err_q, err_d;
    logic [REMOVED_W-1:0] removed_q, removed_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 run_inc_c, run_clr_c, run_hit_c;

    ones_run_counter #(.RUN_LEN(STUFF_RUN)) u_run (
        .clk   (clk),
        .rst   (rst),
        .inc_i (run_inc_c),
        .clr_i (run_clr_c),
        .hit_c (run_hit_c)
    );

    // Next state: pkt_start re-arms first, then the valid bit, then pkt_end closes.
    always_comb begin
        state_d     = state_q;
        eff_state_c = state_q;
        out_d       = out_q;
        out_ready_d = 1'b0;
        err_d       = 1'b0;
        removed_d   = removed_q;
        count_d     = count_q;
        run_inc_c   = 1'b0;
        run_clr_c   = 1'b0;

        if (bus_if.pkt_start) begin
            eff_state_c = UNS_DATA;
            removed_d   = '0;
            count_d     = '0;
            run_clr_c   = 1'b1;
        end
        state_d = eff_state_c;

        case (eff_state_c)
            UNS_DATA: begin
                if (bus_if.bstr_in_ready) begin
                    out_d       = bus_if.bstr_in;
                    out_ready_d = 1'b1;
                    if (count_d != '1) begin
                        count_d = count_d + CNT_W'(1);
                    end
                    if (bus_if.bstr_in) begin
                        run_inc_c = 1'b1;
                        if (run_hit_c) begin
                            state_d = UNS_DROP;
                        end
                    end else begin
                        run_clr_c = 1'b1;
                    end
                end
            end
            UNS_DROP: begin
                if (bus_if.bstr_in_ready) begin
                    if (!bus_if.bstr_in) begin
                        if (removed_d != '1) begin
                            removed_d = removed_d + REMOVED_W'(1);
                        end
                        run_clr_c = 1'b1;
                        state_d   = UNS_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = UNS_ERR;
                    end
                end
            end
            default: ;
        endcase

        if (bus_if.pkt_end && eff_state_c != UNS_IDLE) begin
            if (state_d == UNS_DROP) begin
                err_d = 1'b1;
            end
            state_d = UNS_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNS_IDLE;
            out_q       <= 1'b0;
            out_ready_q <= 1'b0;
            err_q       <= 1'b0;
            removed_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_ready_q <= out_ready_d;
            err_q       <= err_d;
            removed_q   <= removed_d;
            count_q     <= count_d;
        end
    end

    assign bus_if.bstr_out       = out_q;
    assign bus_if.bstr_out_ready = out_ready_q;
    assign bus_if.stuff_err      = err_q;
    assign bus_if.bits_removed   = removed_q;
    assign bus_if.bit_count      = count_q;

endmodule

// File: tb/tb_bit_unstuffer.sv
// Directed self-checking bench for bit_unstuffer.
module tb_bit_unstuffer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bit_unstuffer_if #(.CNT_W(7)) bif ();

    bit_unstuffer #(.STUFF_RUN(6), .CNT_W(7)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic s;
        logic e;
        logic v;
        logic b;
        logic ready;
        logic out;
        logic err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the clock edge.
    task automatic step(input logic s, input logic e, input logic v, input logic b);
        bif.pkt_start     = s;
        bif.pkt_end       = e;
        bif.bstr_in_ready = v;
        bif.bstr_in       = b;
        @(posedge clk);
        #1;
        bif.pkt_start     = 1'b0;
        bif.pkt_end       = 1'b0;
        bif.bstr_in_ready = 1'b0;
        bif.bstr_in       = 1'b0;
    endtask

    initial begin
        int   delivered;
        int   ones;
        int   err_seen;
        int   spurious;
        logic seq_q[$];

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bif.pkt_start = 1'b0;
        bif.pkt_end = 1'b0;
        bif.bstr_in = 1'b0;
        bif.bstr_in_ready = 1'b0;

        // Test 1: reset for two cycles, then bits without pkt_start are ignored.
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_ready", int'(bif.bstr_out_ready), 0);
        chk("rst out", int'(bif.bstr_out), 0);
        chk("rst err", int'(bif.stuff_err), 0);
        chk("rst removed", int'(bif.bits_removed), 0);
        chk("rst count", int'(bif.bit_count), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            chk("idle ready", int'(bif.bstr_out_ready), 0);
        end

        // Test 2: six 1s, stuffed 0, one more 1.
        tbl.push_back('{1, 0, 1, 1, 1, 1, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 1, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
        // Test 3: seven 1s -> error, then ignored until pkt_end.
        tbl.push_back('{1, 0, 1, 1, 1, 1, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 1, 1, 1, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].e, tbl[i].v, tbl[i].b);
            chk($sformatf("vec%0d ready", i), int'(bif.bstr_out_ready), int'(tbl[i].ready));
            if (tbl[i].ready) begin
                chk($sformatf("vec%0d out", i), int'(bif.bstr_out), int'(tbl[i].out));
            end
            chk($sformatf("vec%0d err", i), int'(bif.stuff_err), int'(tbl[i].err));
            if (i == 8) begin
                chk("t2 removed", int'(bif.bits_removed), 1);
                chk("t2 count", int'(bif.bit_count), 7);
            end
        end
        chk("t3 removed", int'(bif.bits_removed), 0);
        chk("t3 count", int'(bif.bit_count), 6);

        // Test 4: test 2 stream with random gaps.
        delivered = 0;
        spurious = 0;
        err_seen = 0;
        seq_q.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = (i == 6) ? 1'b0 : 1'b1;
            repeat ($urandom_range(0, 3)) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                if (bif.bstr_out_ready) spurious++;
            end
            step(1'b0, 1'b0, 1'b1, b);
            if (bif.bstr_out_ready) seq_q.push_back(bif.bstr_out);
            if (bif.stuff_err) err_seen++;
        end
        chk("t4 gap ready", spurious, 0);
        chk("t4 delivered", seq_q.size(), 7);
        ones = 0;
        foreach (seq_q[k]) if (seq_q[k]) ones++;
        chk("t4 ones", ones, 7);
        chk("t4 err", err_seen, 0);
        chk("t4 removed", int'(bif.bits_removed), 1);

        // Test 5: 64 ones with stuffed zeros, then packet ending owing a zero.
        delivered = 0;
        ones = 0;
        err_seen = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (bif.bstr_out_ready) begin
                delivered++;
                if (bif.bstr_out) ones++;
            end
            if (bif.stuff_err) err_seen++;
            if (i % 6 == 0) begin
                step(1'b0, 1'b0, 1'b1, 1'b0);
                if (bif.bstr_out_ready) delivered++;
                if (bif.stuff_err) err_seen++;
            end
        end
        chk("t5 delivered", delivered, 64);
        chk("t5 ones", ones, 64);
        chk("t5 err", err_seen, 0);
        chk("t5 removed", int'(bif.bits_removed), 10);
        chk("t5 count", int'(bif.bit_count), 64);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5 pre-end err", int'(bif.stuff_err), 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5 end ready", int'(bif.bstr_out_ready), 1);
        chk("t5 end err", int'(bif.stuff_err), 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5 err pulse", int'(bif.stuff_err), 0);
        chk("t5 idle ready", int'(bif.bstr_out_ready), 0);
        chk("t5 held count", int'(bif.bit_count), 6);

        // Test 6: reset mid-run restarts the run counter.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t6 rst count", int'(bif.bit_count), 0);
        chk("t6 rst ready", int'(bif.bstr_out_ready), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6 b0 ready", int'(bif.bstr_out_ready), 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6 b1 ready", int'(bif.bstr_out_ready), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6 b2 ready", int'(bif.bstr_out_ready), 1);
        chk("t6 b2 out", int'(bif.bstr_out), 0);
        chk("t6 count", int'(bif.bit_count), 3);
        chk("t6 removed", int'(bif.bits_removed), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6 hold out", int'(bif.bstr_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
